// File: rtl/source_block.sv
// source_block: registered 4-input truth-table function unit with optional input capture stage
module source_block #(
    parameter logic [15:0] TRUTH  = 16'h28AC,
    parameter bit          IN_REG = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic       y,
    input  logic [3:0] x
);
    logic [3:0] x_d, x_q;
    logic       y_d, y_q;

    // Capture x every cycle; the result indexes the truth table with x or its registered copy
    always_comb begin
        x_d = x;
        y_d = TRUTH[IN_REG ? x_q : x];
    end

    // Pipeline registers; async reset clears both so y reads 0 immediately and any pending x is lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= 4'b0000;
            y_q <= 1'b0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign y = y_q;
endmodule

// File: tb/tb_source_block.sv
// tb_source_block: checks direct, input-registered and overridden-truth variants against a prime/endpoint model
module tb_source_block;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] x;
    logic       y0, y1, y2;
    int         total = 0;
    int         passed = 0;
    logic [3:0] h0 = 4'd0;
    logic [3:0] h1 = 4'd0;
    int         n = 0;
    logic [15:0] sweep_exp = 16'b0010_1000_1010_1100;

    source_block dut0 (.clk(clk), .rst(rst), .y(y0), .x(x));
    source_block #(.IN_REG(1'b1)) dut1 (.clk(clk), .rst(rst), .y(y1), .x(x));
    source_block #(.TRUTH(16'h8001)) dut2 (.clk(clk), .rst(rst), .y(y2), .x(x));

    always #5 clk = ~clk;

    function automatic logic prime(input logic [3:0] v);
        int vi = int'(v);
        if (vi < 2) return 1'b0;
        for (int d = 2; d < vi; d++) if (vi % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic ends(input logic [3:0] v);
        return (v == 4'd0) || (v == 4'd15);
    endfunction

    task automatic chk(input string tag, input logic o, input logic e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s observed=%b expected=%b at %0t", tag, o, e, $time);
    endtask

    task automatic check_all;
        chk("y_direct", y0, n >= 1 ? prime(h0) : 1'b0);
        chk("y_inreg", y1, n >= 2 ? prime(h1) : (n == 1 ? prime(4'd0) : 1'b0));
        chk("y_truth8001", y2, n >= 1 ? ends(h0) : 1'b0);
    endtask

    task automatic cyc;
        @(posedge clk);
        if (rst) n = 0;
        else begin
            h1 = h0;
            h0 = x;
            n++;
        end
        #1;
        check_all;
    endtask

    task automatic rst_on;
        rst = 1'b1;
        #1;
        n = 0;
        check_all;
    endtask

    initial begin
        x = 4'b0010;
        rst = 1'b1;
        #1;
        check_all;
        repeat (3) cyc;
        chk("reset_hold_y", y0, 1'b0);
        #2 rst = 1'b0;
        for (int v = 0; v < 16; v++) begin
            x = 4'(v);
            cyc;
            chk("sweep_direct", y0, sweep_exp[v]);
            cyc;
        end
        x = 4'b0100;
        cyc;
        cyc;
        x = 4'b0101;
        cyc;
        chk("latency_edge1", y1, 1'b0);
        cyc;
        chk("latency_edge2", y1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            x = i[0] ? 4'b1110 : 4'b1101;
            cyc;
        end
        x = 4'b1101;
        cyc;
        cyc;
        chk("pre_reset_high", y0, 1'b1);
        rst_on;
        chk("async_drop", y0, 1'b0);
        cyc;
        x = 4'b0011;
        #2 rst = 1'b0;
        cyc;
        chk("release_direct", y0, 1'b1);
        chk("release_inreg_first", y1, 1'b0);
        cyc;
        chk("release_inreg_second", y1, 1'b1);
        for (int i = 0; i < 300; i++) begin
            x = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) begin
                rst_on;
                cyc;
                #2 rst = 1'b0;
            end
            cyc;
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
